pila_retorno: RTL and testbench

- Hardware return-address stack (LIFO) that feeds the program counter's `pila` input.
- The control unit pushes the return address (pcout+1) on a call and pops on a return.
- The PC loads `top` on the same clock edge as the pop (cs=5'b11101).
- Purely synchronous register storage with zero-latency top-of-stack read, plus full/empty status and sticky error flags.

---
 rtl/vn_pkg.sv | 22 ++
 rtl/pila_mem.sv | 29 ++
 rtl/pila_retorno.sv | 126 ++++++++++++
 tb/tb_pila_retorno.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vn_pkg.sv
// Shared definitions for the PC / return-stack datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vn_pkg;

    // Program-counter / return-address width.
    localparam int AW = 8;

    // Control-unit cs encodings that touch the PC source mux.
    localparam logic [4:0] CS_JUMP = 5'b11110;
    localparam logic [4:0] CS_INC  = 5'b11111;
    localparam logic [4:0] CS_RET  = 5'b11101;

    // Decoded stack operation for one clock edge.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_SWAP
    } stack_op_t;

endpackage

// File: rtl/pila_mem.sv
// DEPTH x AW register file: one synchronous write port, one asynchronous read port.
// Latency: write visible one edge after we; read is combinational.
// Backpressure: none, accepts a write every cycle.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
// Storage is deliberately not reset; validity is tracked by the owner.
module pila_mem #(
    parameter int AW    = 8,
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pila_retorno.sv
// Return-address stack (LIFO) feeding the PC `pila` input; sticky overflow/underflow.
// Latency: top is combinational from registers; push/pop take effect on the next rising edge.
// Backpressure: none; push-when-full and pop-when-empty are absorbed and flagged.
// Ports: clk, reset (async, active-high); push/pop/din/clr_err in;
//        top, count, empty, full, overflow, underflow out.
// Build option: define PILA_WRAP_EN to make push-when-full overwrite the oldest entry.
module pila_retorno
    import vn_pkg::*;
#(
    parameter int AW    = vn_pkg::AW,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    input  logic          clr_err,
    output logic [AW-1:0] top,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam int            SPW      = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [SPW-1:0] sp, sp_nxt, sp_m1;
    logic [CW-1:0]  count_nxt;
    logic           wr_en;
    logic [SPW-1:0] wr_addr;
    logic [AW-1:0]  rd_dat;
    logic           ovf_set, unf_set;
    stack_op_t      op;

    assign sp_m1 = sp - SPW'(1);
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // When empty the stale slot below sp must not leak onto the PC bus.
    assign top   = empty ? '0 : rd_dat;

    always_comb begin
        op = OP_NONE;
        if (push && pop) op = OP_SWAP;
        else if (push)   op = OP_PUSH;
        else if (pop)    op = OP_POP;
    end

    always_comb begin
        sp_nxt    = sp;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_addr   = sp;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    wr_en     = 1'b1;
                    sp_nxt    = sp + SPW'(1);
                    count_nxt = count + CW'(1);
                end else begin
                    ovf_set = 1'b1;
`ifdef PILA_WRAP_EN
                    // When full, sp already points at the oldest entry.
                    wr_en  = 1'b1;
                    sp_nxt = sp + SPW'(1);
`endif
                end
            end
            OP_POP: begin
                if (!empty) begin
                    sp_nxt    = sp_m1;
                    count_nxt = count - CW'(1);
                end else begin
                    unf_set = 1'b1;
                end
            end
            OP_SWAP: begin
                wr_en = 1'b1;
                if (!empty) begin
                    // Tail call: return then call collapses to overwriting the top.
                    wr_addr = sp_m1;
                end else begin
                    // Nothing to return from: flag it, then the call still lands.
                    unf_set   = 1'b1;
                    sp_nxt    = sp + SPW'(1);
                    count_nxt = CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            count     <= count_nxt;
            // A new error in the same cycle as clr_err wins.
            overflow  <= ovf_set | (overflow  & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end

    pila_mem #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .PW    (SPW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (din),
        .raddr (sp_m1),
        .rdata (rd_dat)
    );

endmodule

// File: tb/tb_pila_retorno.sv
// Directed bench for pila_retorno (DEPTH=8, AW=8).
// Latency: n/a. Backpressure: n/a.
// Expectations follow PILA_WRAP_EN when it is defined for the build.
module tb_pila_retorno;

    logic       clk = 1'b0;
    logic       reset;
    logic       push, pop, clr_err;
    logic [7:0] din;
    logic [7:0] top;
    logic [3:0] count;
    logic       empty, full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pila_retorno #(.AW(8), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .clr_err   (clr_err),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Advance one active edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = 8'h00;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rst_empty got %b want 1", empty); end
        checks++; if (count !== 4'd0)     begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (top !== 8'h00)      begin errors++; $display("FAIL rst_top got %h want 00", top); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL rst_full got %b want 0", full); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_unf got %b want 0", underflow); end
    endtask

    task automatic test_push_pop();
        logic [7:0] vals [3];
        logic [7:0] exp_top [3];
        vals    = '{8'h10, 8'h21, 8'h32};
        exp_top = '{8'h21, 8'h10, 8'h00};
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = vals[i];
            step();
        end
        push = 1'b0;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL pp_count got %0d want 3", count); end
        checks++; if (top !== 8'h32)  begin errors++; $display("FAIL pp_top got %h want 32", top); end
        pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (top !== exp_top[i]) begin errors++; $display("FAIL pp_pop%0d_top got %h want %h", i, top, exp_top[i]); end
        end
        pop = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty got %b want 1", empty); end
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set got %b want 1", underflow); end
        checks++; if (count !== 4'd0)     begin errors++; $display("FAIL unf_count got %0d want 0", count); end
        checks++; if (top !== 8'h00)      begin errors++; $display("FAIL unf_top got %h want 00", top); end
        clr_err = 1'b1;
        step();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr got %b want 0", underflow); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set_wins got %b want 1", underflow); end
        step();
        clr_err = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr2 got %b want 0", underflow); end
    endtask

    task automatic test_full();
        logic [7:0] exp;
        push = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = 8'(i);
            step();
        end
        push = 1'b0;
        checks++; if (full !== 1'b1)  begin errors++; $display("FAIL full_flag got %b want 1", full); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", count); end
        checks++; if (top !== 8'h08)  begin errors++; $display("FAIL full_top got %h want 08", top); end
        push = 1'b1; din = 8'h09;
        step();
        push = 1'b0;
`ifdef PILA_WRAP_EN
        exp = 8'h09;
`else
        exp = 8'h08;
`endif
        checks++; if (top !== exp)        begin errors++; $display("FAIL ovf_top got %h want %h", top, exp); end
        checks++; if (count !== 4'd8)     begin errors++; $display("FAIL ovf_count got %0d want 8", count); end
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (top !== exp) begin errors++; $display("FAIL drain%0d_top got %h want %h", i, top, exp); end
            step();
            exp = exp - 8'h01;
        end
        pop = 1'b0;
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
        checks++; if (top !== 8'h00)     begin errors++; $display("FAIL drain_top got %h want 00", top); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
    endtask

    task automatic test_swap();
        push = 1'b1;
        din = 8'h30; step();
        din = 8'h40; step();
        pop = 1'b1; din = 8'h55;
        step();
        push = 1'b0;
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL swap_count got %0d want 2", count); end
        checks++; if (top !== 8'h55)  begin errors++; $display("FAIL swap_top got %h want 55", top); end
        step();
        checks++; if (top !== 8'h30)  begin errors++; $display("FAIL swap_pop_top got %h want 30", top); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL swap_pop_count got %0d want 1", count); end
        step();
        pop = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL swap_empty got %b want 1", empty); end
    endtask

    task automatic test_async_reset();
        // Swap on empty: flags underflow and still pushes.
        push = 1'b1; pop = 1'b1; din = 8'hA1;
        step();
        pop = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL swap_empty_unf got %b want 1", underflow); end
        checks++; if (count !== 4'd1)     begin errors++; $display("FAIL swap_empty_count got %0d want 1", count); end
        checks++; if (top !== 8'hA1)      begin errors++; $display("FAIL swap_empty_top got %h want a1", top); end
        for (int i = 2; i <= 5; i++) begin
            din = 8'hA0 + 8'(i);
            step();
        end
        push = 1'b0;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL ar_pre_count got %0d want 5", count); end
        checks++; if (top !== 8'hA5)  begin errors++; $display("FAIL ar_pre_top got %h want a5", top); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (count !== 4'd0)     begin errors++; $display("FAIL ar_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL ar_empty got %b want 1", empty); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ar_unf got %b want 0", underflow); end
        checks++; if (top !== 8'h00)      begin errors++; $display("FAIL ar_top got %h want 00", top); end
        #1;
        reset = 1'b0;
        push = 1'b1; din = 8'hAA;
        step();
        push = 1'b0;
        checks++; if (top !== 8'hAA)  begin errors++; $display("FAIL ar_push_top got %h want aa", top); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL ar_push_count got %0d want 1", count); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_underflow();
        test_full();
        test_swap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
